// File: rtl/pc_unit.sv
// Program counter unit: BOOT/RUN/HALTED fetch-address generator with trap/redirect
// priority, a single pending-target slot and forced target alignment.
module pc_unit #(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [XLEN-1:0] INC          = XLEN'(4),
  parameter int unsigned     ALIGN_BITS   = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_vector,
  input  logic            halt,
  input  logic            imem_ready,
  output logic [XLEN-1:0] pc_out,
  output logic            pc_valid,
  output logic [XLEN-1:0] pc_next_seq,
  output logic            misalign
);

  localparam logic [1:0] ST_BOOT   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  function automatic logic [XLEN-1:0] align_mask();
    logic [XLEN-1:0] m;
    m = '1;
    return m << ALIGN_BITS;
  endfunction

  function automatic logic [XLEN-1:0] align_addr(input logic [XLEN-1:0] a);
    return a & align_mask();
  endfunction

  function automatic logic is_misaligned(input logic [XLEN-1:0] a);
    return (a & ~align_mask()) != '0;
  endfunction

  logic [1:0]      state_r, state_s;
  logic [XLEN-1:0] pc_r, pc_s;
  logic            valid_r, valid_s;
  logic            misalign_r, misalign_s;
  logic            pend_valid_r, pend_valid_s;
  logic            pend_trap_r, pend_trap_s;
  logic [XLEN-1:0] pend_target_r, pend_target_s;
  logic            accept_s;
  logic            apply_s;
  logic [XLEN-1:0] target_s;

  assign accept_s    = valid_r & imem_ready & ~stall;
  assign pc_next_seq = pc_r + INC;
  assign pc_out      = pc_r;
  assign pc_valid    = valid_r;
  assign misalign    = misalign_r;

  // Next-state, next-PC and pending-slot selection
  always_comb begin
    state_s       = state_r;
    pc_s          = pc_r;
    valid_s       = valid_r;
    misalign_s    = 1'b0;
    pend_valid_s  = pend_valid_r;
    pend_trap_s   = pend_trap_r;
    pend_target_s = pend_target_r;
    apply_s       = 1'b0;
    target_s      = '0;
    case (state_r)
      ST_BOOT: begin
        state_s      = ST_RUN;
        pc_s         = RESET_VECTOR;
        valid_s      = 1'b1;
        pend_valid_s = 1'b0;
        pend_trap_s  = 1'b0;
      end
      ST_RUN: begin
        if (accept_s) begin
          if (trap_valid) begin
            apply_s  = 1'b1;
            target_s = trap_vector;
          end else if (redirect_valid) begin
            apply_s  = 1'b1;
            target_s = redirect_target;
          end else if (pend_valid_r) begin
            apply_s  = 1'b1;
            target_s = pend_target_r;
          end else begin
            pc_s = pc_next_seq;
          end
          pend_valid_s = 1'b0;
          pend_trap_s  = 1'b0;
          if (halt) begin
            state_s = ST_HALTED;
            valid_s = 1'b0;
          end else begin
            state_s = ST_RUN;
          end
        end else if (trap_valid) begin
          pend_valid_s  = 1'b1;
          pend_trap_s   = 1'b1;
          pend_target_s = trap_vector;
        end else if (redirect_valid && !(pend_valid_r && pend_trap_r)) begin
          // A queued trap is never displaced by a later redirect
          pend_valid_s  = 1'b1;
          pend_trap_s   = 1'b0;
          pend_target_s = redirect_target;
        end else begin
          pend_valid_s = pend_valid_r;
        end
      end
      ST_HALTED: begin
        if (trap_valid) begin
          apply_s      = 1'b1;
          target_s     = trap_vector;
          state_s      = ST_RUN;
          valid_s      = 1'b1;
          pend_valid_s = 1'b0;
          pend_trap_s  = 1'b0;
        end else if (redirect_valid) begin
          apply_s  = 1'b1;
          target_s = redirect_target;
        end else if (!halt) begin
          state_s = ST_RUN;
          valid_s = 1'b1;
          if (pend_valid_r) begin
            apply_s      = 1'b1;
            target_s     = pend_target_r;
            pend_valid_s = 1'b0;
            pend_trap_s  = 1'b0;
          end else begin
            pc_s = pc_r;
          end
        end else begin
          state_s = ST_HALTED;
        end
      end
      default: begin
        state_s      = ST_BOOT;
        pc_s         = RESET_VECTOR;
        valid_s      = 1'b0;
        pend_valid_s = 1'b0;
        pend_trap_s  = 1'b0;
      end
    endcase
    if (apply_s) begin
      pc_s       = align_addr(target_s);
      misalign_s = is_misaligned(target_s);
    end else begin
      misalign_s = 1'b0;
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r       <= ST_BOOT;
      pc_r          <= RESET_VECTOR;
      valid_r       <= 1'b0;
      misalign_r    <= 1'b0;
      pend_valid_r  <= 1'b0;
      pend_trap_r   <= 1'b0;
      pend_target_r <= '0;
    end else begin
      state_r       <= state_s;
      pc_r          <= pc_s;
      valid_r       <= valid_s;
      misalign_r    <= misalign_s;
      pend_valid_r  <= pend_valid_s;
      pend_trap_r   <= pend_trap_s;
      pend_target_r <= pend_target_s;
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed scenarios plus randomized traffic
// compared against a queue-based behavioural model of the fetch address.
module tb_pc_unit;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, stall, redirect_valid, trap_valid, halt, imem_ready;
  logic [31:0] redirect_target, trap_vector;
  logic [31:0] pc_out, pc_next_seq;
  logic        pc_valid, misalign;
  logic        r8_valid, t8_valid;
  logic [7:0]  r8_target, t8_vector;
  logic [7:0]  pc_out8, pc_next_seq8;
  logic        pc_valid8, misalign8;

  int checks = 0;
  int errors = 0;

  pc_unit u_dut (
    .clk(clk), .reset(reset), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .trap_valid(trap_valid), .trap_vector(trap_vector),
    .halt(halt), .imem_ready(imem_ready),
    .pc_out(pc_out), .pc_valid(pc_valid), .pc_next_seq(pc_next_seq), .misalign(misalign)
  );

  pc_unit #(.XLEN(8), .RESET_VECTOR(8'h00), .INC(8'd4), .ALIGN_BITS(2)) u_dut8 (
    .clk(clk), .reset(reset), .stall(stall),
    .redirect_valid(r8_valid), .redirect_target(r8_target),
    .trap_valid(t8_valid), .trap_vector(t8_vector),
    .halt(halt), .imem_ready(imem_ready),
    .pc_out(pc_out8), .pc_valid(pc_valid8), .pc_next_seq(pc_next_seq8), .misalign(misalign8)
  );

  // Behavioural model of the 32-bit instance
  typedef struct {
    logic [31:0] addr;
    bit          trap;
  } pend_t;
  pend_t       pend_q[$];
  bit          m_boot, m_halted, m_mis;
  logic [31:0] m_pc;

  function automatic logic [31:0] seq_of(input logic [31:0] p);
    longint unsigned s;
    s = {32'd0, p} + 64'd4;
    return 32'(s % 64'h1_0000_0000);
  endfunction

  task automatic model_reset();
    m_boot = 1'b1; m_halted = 1'b0; m_mis = 1'b0; m_pc = 32'h0;
    pend_q.delete();
  endtask

  task automatic model_apply(input logic [31:0] t);
    m_pc  = t - (t % 32'd4);
    m_mis = (t % 32'd4) != 32'd0;
  endtask

  task automatic model_step();
    bit acc;
    acc = imem_ready && !stall;
    m_mis = 1'b0;
    if (m_boot) begin
      m_boot = 1'b0; m_pc = 32'h0; pend_q.delete();
    end else if (!m_halted) begin
      if (acc) begin
        if (trap_valid) model_apply(trap_vector);
        else if (redirect_valid) model_apply(redirect_target);
        else if (pend_q.size() > 0) model_apply(pend_q[0].addr);
        else m_pc = seq_of(m_pc);
        pend_q.delete();
        if (halt) m_halted = 1'b1;
      end else if (trap_valid) begin
        pend_q.delete();
        pend_q.push_back('{addr: trap_vector, trap: 1'b1});
      end else if (redirect_valid && !(pend_q.size() > 0 && pend_q[0].trap)) begin
        pend_q.delete();
        pend_q.push_back('{addr: redirect_target, trap: 1'b0});
      end
    end else begin
      if (trap_valid) begin
        model_apply(trap_vector); m_halted = 1'b0; pend_q.delete();
      end else if (redirect_valid) begin
        model_apply(redirect_target);
      end else if (!halt) begin
        m_halted = 1'b0;
        if (pend_q.size() > 0) begin
          model_apply(pend_q[0].addr); pend_q.delete();
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) model_step();
    #1;
  endtask

  task automatic idle_inputs();
    stall = 1'b0; redirect_valid = 1'b0; trap_valid = 1'b0; halt = 1'b0;
    imem_ready = 1'b1; redirect_target = 32'h0; trap_vector = 32'h0;
    r8_valid = 1'b0; t8_valid = 1'b0; r8_target = 8'h0; t8_vector = 8'h0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (pc_out !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h want %h", pc_out, 32'h0); end
    checks++; if (pc_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", pc_valid); end
    checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL reset_misalign: got %b want 0", misalign); end
    checks++; if (pc_out8 !== 8'h0) begin errors++; $display("FAIL reset_pc8: got %h want 00", pc_out8); end
    reset = 1'b1;
    #1;
    checks++; if (pc_valid !== 1'b0) begin errors++; $display("FAIL boot_valid: got %b want 0", pc_valid); end
  endtask

  task automatic test_sequential();
    logic [31:0] want;
    for (int i = 0; i < 4; i++) begin
      tick();
      want = 32'(i * 4);
      checks++; if (pc_out !== want || pc_out !== m_pc) begin errors++; $display("FAIL seq_pc[%0d]: got %h want %h", i, pc_out, want); end
      checks++; if (pc_valid !== 1'b1) begin errors++; $display("FAIL seq_valid[%0d]: got %b want 1", i, pc_valid); end
    end
    checks++; if (pc_next_seq !== 32'h10) begin errors++; $display("FAIL seq_next: got %h want %h", pc_next_seq, 32'h10); end
  endtask

  task automatic test_stall_redirect();
    tick();
    checks++; if (pc_out !== 32'h10) begin errors++; $display("FAIL hold_start: got %h want %h", pc_out, 32'h10); end
    imem_ready = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      redirect_valid  = (c == 2);
      redirect_target = 32'h40;
      tick();
      checks++; if (pc_out !== 32'h10) begin errors++; $display("FAIL hold_pc[%0d]: got %h want %h", c, pc_out, 32'h10); end
    end
    redirect_valid = 1'b0;
    imem_ready = 1'b1;
    tick();
    checks++; if (pc_out !== 32'h40 || pc_out !== m_pc) begin errors++; $display("FAIL pend_redirect: got %h want %h", pc_out, 32'h40); end
  endtask

  task automatic test_priority();
    redirect_valid = 1'b1; redirect_target = 32'h80;
    trap_valid = 1'b1; trap_vector = 32'h100;
    tick();
    redirect_valid = 1'b0; trap_valid = 1'b0;
    checks++; if (pc_out !== 32'h100) begin errors++; $display("FAIL trap_priority: got %h want %h", pc_out, 32'h100); end
  endtask

  task automatic test_pending_trap();
    tick();
    stall = 1'b1;
    trap_valid = 1'b1; trap_vector = 32'h100;
    tick();
    trap_valid = 1'b0;
    redirect_valid = 1'b1; redirect_target = 32'h80;
    tick();
    redirect_valid = 1'b0;
    checks++; if (pc_out !== 32'h104) begin errors++; $display("FAIL stall_hold: got %h want %h", pc_out, 32'h104); end
    stall = 1'b0;
    tick();
    checks++; if (pc_out !== 32'h100 || pc_out !== m_pc) begin errors++; $display("FAIL pend_trap_kept: got %h want %h", pc_out, 32'h100); end
  endtask

  task automatic test_wrap_misalign();
    r8_valid = 1'b1; r8_target = 8'hFC;
    tick();
    r8_valid = 1'b0;
    checks++; if (pc_out8 !== 8'hFC) begin errors++; $display("FAIL w8_load: got %h want fc", pc_out8); end
    checks++; if (pc_next_seq8 !== 8'h00) begin errors++; $display("FAIL w8_next: got %h want 00", pc_next_seq8); end
    tick();
    checks++; if (pc_out8 !== 8'h00) begin errors++; $display("FAIL w8_wrap: got %h want 00", pc_out8); end
    checks++; if (misalign8 !== 1'b0) begin errors++; $display("FAIL w8_mis0: got %b want 0", misalign8); end
    r8_valid = 1'b1; r8_target = 8'h43;
    tick();
    r8_valid = 1'b0;
    checks++; if (pc_out8 !== 8'h40) begin errors++; $display("FAIL w8_align: got %h want 40", pc_out8); end
    checks++; if (misalign8 !== 1'b1) begin errors++; $display("FAIL w8_mis1: got %b want 1", misalign8); end
    tick();
    checks++; if (misalign8 !== 1'b0) begin errors++; $display("FAIL w8_mis_pulse: got %b want 0", misalign8); end
    checks++; if (pc_out8 !== 8'h44) begin errors++; $display("FAIL w8_after: got %h want 44", pc_out8); end
  endtask

  task automatic test_halt_trap_reset();
    redirect_valid = 1'b1; redirect_target = 32'h20;
    tick();
    redirect_valid = 1'b0;
    halt = 1'b1;
    tick();
    checks++; if (pc_out !== 32'h24) begin errors++; $display("FAIL halt_pc: got %h want %h", pc_out, 32'h24); end
    checks++; if (pc_valid !== 1'b0) begin errors++; $display("FAIL halt_valid: got %b want 0", pc_valid); end
    tick();
    checks++; if (pc_out !== 32'h24 || pc_valid !== 1'b0) begin errors++; $display("FAIL halt_hold: got %h/%b want %h/0", pc_out, pc_valid, 32'h24); end
    trap_valid = 1'b1; trap_vector = 32'h200;
    tick();
    trap_valid = 1'b0; halt = 1'b0;
    checks++; if (pc_out !== 32'h200 || pc_valid !== 1'b1) begin errors++; $display("FAIL halt_trap: got %h/%b want %h/1", pc_out, pc_valid, 32'h200); end
    #2 reset = 1'b0;
    #1;
    model_reset();
    checks++; if (pc_out !== 32'h0 || pc_valid !== 1'b0) begin errors++; $display("FAIL async_reset: got %h/%b want 0/0", pc_out, pc_valid); end
    @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      reset           = 1'b1;
      stall           = ($urandom_range(3) == 0);
      imem_ready      = ($urandom_range(3) != 0);
      redirect_valid  = ($urandom_range(4) == 0);
      trap_valid      = ($urandom_range(11) == 0);
      halt            = ($urandom_range(9) == 0);
      redirect_target = $urandom() & 32'h0000_0FFF;
      trap_vector     = $urandom() & 32'h0000_0FFF;
      if ($urandom_range(49) == 0) begin
        reset = 1'b0;
        #1;
        model_reset();
        checks++; if (pc_out !== 32'h0 || pc_valid !== 1'b0 || misalign !== 1'b0) begin errors++; $display("FAIL rnd_reset[%0d]: got %h/%b/%b want 0/0/0", i, pc_out, pc_valid, misalign); end
      end
      tick();
      checks++; if (pc_out !== m_pc) begin errors++; $display("FAIL rnd_pc[%0d]: got %h want %h", i, pc_out, m_pc); end
      checks++; if (pc_valid !== (!m_boot && !m_halted)) begin errors++; $display("FAIL rnd_valid[%0d]: got %b want %b", i, pc_valid, !m_boot && !m_halted); end
      checks++; if (misalign !== m_mis) begin errors++; $display("FAIL rnd_mis[%0d]: got %b want %b", i, misalign, m_mis); end
      checks++; if (pc_next_seq !== seq_of(m_pc)) begin errors++; $display("FAIL rnd_next[%0d]: got %h want %h", i, pc_next_seq, seq_of(m_pc)); end
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall_redirect();
    test_priority();
    test_pending_trap();
    test_wrap_misalign();
    test_halt_trap_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 Parameter XLEN, default 32, PC width in bits.
REQ-002 Parameter RESET_VECTOR, default 0, PC value loaded by reset.
REQ-003 Parameter INC, default 4, sequential PC increment.
REQ-004 Parameter ALIGN_BITS, default 2, low PC bits that SHALL be zero.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 reset  in  1  asynchronous, active-low (0 = in reset).
REQ-007 stall  in  1  hazard-unit hold; blocks acceptance.
REQ-008 redirect_valid  in  1  branch/jump redirect request.
REQ-009 redirect_target  in  XLEN  branch/jump target.
REQ-010 trap_valid  in  1  trap redirect request.
REQ-011 trap_vector  in  XLEN  trap target.
REQ-012 halt  in  1  request to stop fetching.
REQ-013 imem_ready  in  1  instruction memory accepts pc_out.
REQ-014 pc_out  out  XLEN  current fetch address (registered).
REQ-015 pc_valid  out  1  pc_out is a live fetch request (registered).
REQ-016 pc_next_seq  out  XLEN  pc_out + INC, modulo 2^XLEN (combinational).
REQ-017 misalign  out  1  one-cycle pulse: a misaligned target was applied.

Function
REQ-018 States SHALL be BOOT, RUN, HALTED; pc_valid SHALL be 1 exactly in RUN.
REQ-019 accept SHALL equal pc_valid & imem_ready & !stall.
REQ-020 While pc_valid=1 and accept=0, pc_out SHALL hold its value.
REQ-021 BOOT SHALL last one cycle after reset release, then enter RUN with pc_out=RESET_VECTOR.
REQ-022 Target selection: trap_valid wins over redirect_valid; both win over sequential increment.
REQ-023 RUN, accept=1, no request, no pending: pc_out <= pc_next_seq (wraps modulo 2^XLEN).
REQ-024 RUN, accept=1, request present: pc_out <= selected target; any pending target cleared.
REQ-025 RUN, accept=0, request present: target stored in a single pending register; pc_out unchanged.
REQ-026 Pending overwrite: trap replaces any pending entry; redirect replaces a pending redirect but never a pending trap.
REQ-027 RUN, accept=1, no new request, pending set: pc_out <= pending target, pending cleared.
REQ-028 Any target with nonzero low ALIGN_BITS SHALL be applied with those bits cleared, and misalign SHALL be 1 for the cycle after the pc_out update; otherwise misalign=0.
REQ-029 RUN, halt=1 and accept=1: pc_out takes its normal next value and the state becomes HALTED.
REQ-030 RUN, halt=1 and accept=0: stay in RUN until accept.
REQ-031 HALTED: pc_valid=0; redirect_valid loads pc_out directly, state unchanged.
REQ-032 HALTED: trap_valid loads trap_vector and enters RUN regardless of halt.
REQ-033 HALTED: halt=0 enters RUN with pc_out unchanged; pending entry, if any, applied first.

Reset
REQ-034 reset=0 SHALL immediately, without clk, force state=BOOT, pc_out=RESET_VECTOR, pc_valid=0, misalign=0, pending cleared.
REQ-035 reset asserted mid-operation, including with a pending target or in HALTED, SHALL discard all state per REQ-034.
REQ-036 First accepted address after reset release SHALL be RESET_VECTOR.

Verification
REQ-037 Defaults, reset release, imem_ready=1, stall=0 -> pc_valid rises 1 cycle after release; pc_out = 0, 4, 8, 12 on consecutive cycles.
REQ-038 pc_out=0x10, imem_ready=0 for 3 cycles, redirect_valid=1 to 0x40 in cycle 2 -> pc_out stays 0x10; pc_out=0x40 on the cycle after imem_ready=1.
REQ-039 Same cycle: redirect_valid=1 to 0x80 and trap_valid=1 to 0x100, accept=1 -> pc_out=0x100 next cycle.
REQ-040 Pending trap 0x100, then redirect to 0x80 while stall=1 -> after stall drops and accept, pc_out=0x100.
REQ-041 XLEN=8, pc_out=0xFC, accept -> pc_out=0x00; redirect to 0x43 -> pc_out=0x40 and misalign=1 for one cycle.
REQ-042 halt=1 at pc_out=0x20 with accept -> HALTED, pc_valid=0, pc_out=0x24; trap to 0x200 -> RUN, pc_out=0x200; reset=0 asynchronously mid-cycle -> pc_out=RESET_VECTOR, pc_valid=0 before the next edge.
